// File: rtl/ava_scanout.sv
// Pixel FIFO consumer: VGA raster timing plus one FIFO pixel per active position, with underflow/desync recovery.
// Latency: rgb/de/syncs are registered on the pix_en edge, one clk after the matching pop.
// Backpressure: none upstream; FIFO is popped at the pixel rate, and an empty FIFO degrades to black plus underflow.
module ava_scanout #(
  parameter int COLOR_WIDTH = 12,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIXEL_DIV   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [COLOR_WIDTH-1:0] fifo_data,
  input  logic                   fifo_sof,
  output logic                   fifo_rd_en,
  output logic [COLOR_WIDTH-1:0] rgb,
  output logic                   hsync_n,
  output logic                   vsync_n,
  output logic                   de,
  output logic                   underflow,
  output logic                   desync,
  input  logic                   err_clr
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = $clog2(PIXEL_DIV);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef enum logic {SYNC, RUN} state_t;

  state_t                 state, state_nxt;
  logic [DW-1:0]          div;
  logic [HW-1:0]          h;
  logic [VW-1:0]          v;
  logic                   pix_en;
  logic                   active;
  logic                   at_origin;
  logic                   h_in_sync;
  logic                   v_in_sync;
  logic                   pop;
  logic                   uf_set;
  logic                   ds_set;
  logic [COLOR_WIDTH-1:0] rgb_nxt;

  assign pix_en    = (div == DW'(PIXEL_DIV - 1));
  assign active    = (32'(h) < 32'(H_ACTIVE)) && (32'(v) < 32'(V_ACTIVE));
  assign at_origin = (h == '0) && (v == '0);
  assign h_in_sync = (32'(h) >= 32'(HS_START)) && (32'(h) < 32'(HS_END));
  assign v_in_sync = (32'(v) >= 32'(VS_START)) && (32'(v) < 32'(VS_END));

  // Free-running pixel divider and raster counters; never stalled by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      if (pix_en) div <= '0;
      else        div <= div + 1'b1;
      if (pix_en) begin
        if (h == HW'(H_TOTAL - 1)) begin
          h <= '0;
          if (v == VW'(V_TOTAL - 1)) v <= '0;
          else                       v <= v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // Sync/run state register.
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  // Pop decision, next pixel value, error detection and state transitions.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rgb_nxt   = '0;
    uf_set    = 1'b0;
    ds_set    = 1'b0;
    case (state)
      SYNC: begin
        // Stale words are flushed at clk rate; an SOF head waits for the origin.
        if (!fifo_empty && !fifo_sof) begin
          pop = 1'b1;
        end else if (pix_en && at_origin && !fifo_empty && fifo_sof) begin
          pop       = 1'b1;
          rgb_nxt   = fifo_data;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (pix_en && active) begin
          if (fifo_empty) begin
            uf_set    = 1'b1;
            state_nxt = SYNC;
          end else if (fifo_sof && !at_origin) begin
            ds_set    = 1'b1;
            state_nxt = SYNC;
          end else if (!fifo_sof && at_origin) begin
            ds_set    = 1'b1;
            state_nxt = SYNC;
          end else begin
            pop     = 1'b1;
            rgb_nxt = fifo_data;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign fifo_rd_en = pop && !reset;

  // Video outputs are captured once per pixel and held for the whole pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb     <= '0;
      de      <= 1'b0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else if (pix_en) begin
      rgb     <= rgb_nxt;
      de      <= active;
      hsync_n <= !h_in_sync;
      vsync_n <= !v_in_sync;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
      desync    <= 1'b0;
    end else begin
      if (uf_set)       underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
      if (ds_set)       desync <= 1'b1;
      else if (err_clr) desync <= 1'b0;
    end
  end

endmodule

// File: doc/ava_scanout.md
# ava_scanout

Consumer end of the AVA pixel FIFO. The fill-side controller pushes one pixel per VRAM read and stalls on `pixel_fifo_full`; this block drains that FIFO at the pixel rate. It generates VGA raster timing (hsync, vsync, data-enable) and presents one pixel per active raster position. It also detects FIFO underflow and frame misalignment, and recovers by resynchronising on the next start-of-frame pixel.

## Interface
Parameters:
- `COLOR_WIDTH`, 12, pixel word width (4:4:4 RGB).
- `H_ACTIVE`, `X_RES`, visible pixels per line.
- `H_FP`, 16, horizontal front porch, in pixels.
- `H_SYNC`, 96, hsync width, in pixels.
- `H_BP`, 48, horizontal back porch, in pixels.
- `V_ACTIVE`, `Y_RES`, visible lines.
- `V_FP`, 10, vertical front porch, in lines.
- `V_SYNC`, 2, vsync width, in lines.
- `V_BP`, 33, vertical back porch, in lines.
- `PIXEL_DIV`, 4, clk cycles per pixel (≥2).

Ports:
- `clk`, in, 1, system clock.
- `reset`, in, 1, reset, synchronous, active-high.
- `fifo_empty`, in, 1, pixel FIFO empty.
- `fifo_data`, in, COLOR_WIDTH, FIFO head word (first-word-fall-through; valid while `!fifo_empty`).
- `fifo_sof`, in, 1, FIFO head is pixel (0,0) of a frame.
- `fifo_rd_en`, out, 1, pop FIFO head this cycle.
- `rgb`, out, COLOR_WIDTH, pixel to DAC.
- `hsync_n`, out, 1, horizontal sync, active-low.
- `vsync_n`, out, 1, vertical sync, active-low.
- `de`, out, 1, active-video strobe.
- `underflow`, out, 1, sticky: FIFO empty at an active pixel.
- `desync`, out, 1, sticky: SOF seen away from (0,0), or non-SOF word popped at (0,0).
- `err_clr`, in, 1, clears both sticky flags.

## Operation
- **Pixel divider.** `div` counts 0..PIXEL_DIV-1 and wraps. `pix_en` = (`div` == PIXEL_DIV-1).
- **Raster counters.**
  - `h` counts 0..H_TOTAL-1 on `pix_en`, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - `v` increments when `h` wraps, range 0..V_TOTAL-1; V_TOTAL is defined the same way.
  - Counter widths are `$clog2(TOTAL)`.
- **Derived signals.**
  - active = `h`<H_ACTIVE && `v`<V_ACTIVE.
  - hsync asserted for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for `v` in the corresponding vertical window.
- **FSM states:** SYNC, RUN.
- **SYNC:**
  - While `!fifo_empty && !fifo_sof`: `fifo_rd_en`=1 every clk cycle, discarding stale words.
  - Head with SOF: hold; do not pop.
  - At `pix_en` with `h`==0, `v`==0, `!fifo_empty`, `fifo_sof`: pop, display the word, go to RUN.
  - Active pixels not displayed from the FIFO in SYNC output rgb=0.
- **RUN:** at `pix_en` with active:
  - `!fifo_empty`, head valid for position: pop one word, output it.
  - `fifo_empty`: rgb=0, set `underflow`, go to SYNC.
  - `fifo_sof` at position ≠ (0,0): set `desync`, output 0, do not pop, go to SYNC.
  - Non-SOF head at (0,0): set `desync`, go to SYNC.
  - Blanking positions: no pop; rgb=0.
- **Sticky flags.** `err_clr` clears both. A set event in the same cycle as `err_clr` wins.
- **`fifo_rd_en`** is combinational from state, counters and FIFO status. It is at most one cycle per pixel in RUN.

## Timing
- **Reset values:**
  - `div`/`h`/`v` = 0, state = SYNC.
  - rgb = 0, de = 0, `hsync_n` = 1, `vsync_n` = 1.
  - `fifo_rd_en` = 0, `underflow` = 0, `desync` = 0.
- **Reset mid-frame:** all of the above apply on the next edge; the first `pix_en` occurs PIXEL_DIV cycles after reset deasserts.
- **Output registers.** rgb, de, `hsync_n`, `vsync_n` update only on `pix_en` edges. They reflect the `h`/`v` of that `pix_en`, so latency is one clk cycle after the pop. They hold for PIXEL_DIV cycles.
- **Pop/data alignment.** The pop and the rgb capture happen at the same `pix_en` edge. Data is sampled from `fifo_data` in the cycle `fifo_rd_en`=1.
- **Sync stability.** hsync/vsync continue unaffected by FSM state; raster timing never stalls.
- **Resync.** After an error, the earliest recovery is the next (0,0) position, i.e. up to one frame later.

## Test plan
- **Reset then steady frame.**
  - Stimulus: reset, FIFO preloaded with an SOF word then continuously refilled, small params (H_ACTIVE=8, V_ACTIVE=4, porches 1/2/1, PIXEL_DIV=2).
  - Response: first `de` at pixel (0,0) with the SOF data; exactly 32 pops per frame; `hsync_n` low for 2 pixels per line.
- **Stale-data flush.**
  - Stimulus: 5 non-SOF words, then SOF.
  - Response: 5 back-to-back single-cycle pops in SYNC; SOF held until (0,0); rgb=0 beforehand.
- **Underflow.**
  - Stimulus: empty the FIFO at pixel (3,1).
  - Response: rgb=0 at (3,1); `underflow`=1; no pops until next-frame SOF at (0,0); raster counters unaffected.
- **Misplaced SOF.**
  - Stimulus: SOF head at (5,2) in RUN.
  - Response: `desync`=1; no pop; SYNC state; recovery at next (0,0).
- **`err_clr` collision.**
  - Stimulus: assert `err_clr` in the same cycle as an underflow event.
  - Response: `underflow` remains 1; a later `err_clr` alone clears it to 0.
- **Reset mid-line.**
  - Stimulus: assert reset at `h`=4.
  - Response: next cycle `h`=`v`=0, sync outputs high, `de`=0, state SYNC.
